// File: rtl/maxnet_sequencer.sv
// Generic show-ahead FIFO (power-of-two depth); rd_dat is the current head, no read latency.
// Writes while full and reads while empty are dropped, so callers may gate loosely.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   core_clk,
   input  logic                   arst_n,
   input  logic                   wr_vld,
   input  logic [W-1:0]           wr_dat,
   input  logic                   rd_rdy,
   output logic [W-1:0]           rd_dat,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_en;
   logic          rd_en;

   assign wr_en  = wr_vld && (count != FULL);
   assign rd_en  = rd_rdy && (count != '0);
   assign rd_dat = mem[rd_ptr];

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge core_clk) begin
      if (wr_en) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// Buffers 4-element vectors and runs each through Maxnet with a 2-cycle start, returning max or a timeout flag.
// Pop->out_valid = 3 + Maxnet latency + 1 cycles; in_ready drops when full, jobs stall while out_ready is low.
module maxnet_sequencer #(
   parameter int WIDTH   = 5,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_x1,
   input  logic [WIDTH-1:0]       in_x2,
   input  logic [WIDTH-1:0]       in_x3,
   input  logic [WIDTH-1:0]       in_x4,
   output logic                   mx_start,
   output logic [WIDTH-1:0]       mx_x1,
   output logic [WIDTH-1:0]       mx_x2,
   output logic [WIDTH-1:0]       mx_x3,
   output logic [WIDTH-1:0]       mx_x4,
   input  logic                   mx_done,
   input  logic [WIDTH-1:0]       mx_result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_result,
   output logic                   out_timeout,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] FULL  = CW'(DEPTH);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef struct packed {
      logic [WIDTH-1:0] x1;
      logic [WIDTH-1:0] x2;
      logic [WIDTH-1:0] x3;
      logic [WIDTH-1:0] x4;
   } vec_t;

   typedef enum logic [2:0] {
      IDLE, LOAD, START1, START2, WAIT, OUT
   } state_t;

   state_t        state;
   state_t        state_nxt;
   vec_t          in_vec;
   vec_t          head;
   vec_t          ops;
   logic [TW-1:0] wait_cnt;
   logic          pop;
   logic          cnt_clr;
   logic          cnt_inc;
   logic          cap_done;
   logic          cap_to;

   assign in_vec   = {in_x1, in_x2, in_x3, in_x4};
   assign in_ready = (fifo_count != FULL);

   sync_fifo #(
      .W     ($bits(vec_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .core_clk (clk),
      .arst_n   (rst),
      .wr_vld   (in_valid && in_ready),
      .wr_dat   (in_vec),
      .rd_rdy   (pop),
      .rd_dat   (head),
      .count    (fifo_count)
   );

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      cap_done  = 1'b0;
      cap_to    = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_count != '0) begin
               pop       = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD:   state_nxt = START1;
         START1: state_nxt = START2;
         START2: begin
            cnt_clr   = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            // Done is checked first so it wins a tie with the last timeout cycle.
            if (mx_done) begin
               cap_done  = 1'b1;
               state_nxt = OUT;
            end else if (wait_cnt == TLAST) begin
               cap_to    = 1'b1;
               state_nxt = OUT;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         OUT: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs are flopped from the next state so every output comes straight off a register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ops         <= '0;
         wait_cnt    <= '0;
         out_result  <= '0;
         out_timeout <= 1'b0;
         mx_start    <= 1'b0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state <= state_nxt;
         if (pop) ops <= head;
         if (cnt_clr)      wait_cnt <= '0;
         else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
         if (cap_done) begin
            out_result  <= mx_result;
            out_timeout <= 1'b0;
         end else if (cap_to) begin
            out_result  <= '0;
            out_timeout <= 1'b1;
         end
         mx_start  <= (state_nxt == START1) || (state_nxt == START2);
         out_valid <= (state_nxt == OUT);
         busy      <= (state_nxt != IDLE);
      end
   end

   assign mx_x1 = ops.x1;
   assign mx_x2 = ops.x2;
   assign mx_x3 = ops.x3;
   assign mx_x4 = ops.x4;
endmodule

// File: tb/tb_maxnet_sequencer.sv
// Directed bench for maxnet_sequencer with a behavioural Maxnet stub whose done latency is adjustable.
module tb_maxnet_sequencer;
   localparam int WIDTH   = 5;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_x1, in_x2, in_x3, in_x4;
   logic             mx_start;
   logic [WIDTH-1:0] mx_x1, mx_x2, mx_x3, mx_x4;
   logic             mx_done;
   logic [WIDTH-1:0] mx_result;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_timeout;
   logic             busy;
   logic [2:0]       fifo_count;

   int checks = 0;
   int errors = 0;
   bit stub_en;
   int stub_lat;

   always #5 clk = ~clk;

   maxnet_sequencer #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_x1       (in_x1),
      .in_x2       (in_x2),
      .in_x3       (in_x3),
      .in_x4       (in_x4),
      .mx_start    (mx_start),
      .mx_x1       (mx_x1),
      .mx_x2       (mx_x2),
      .mx_x3       (mx_x3),
      .mx_x4       (mx_x4),
      .mx_done     (mx_done),
      .mx_result   (mx_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_timeout (out_timeout),
      .busy        (busy),
      .fifo_count  (fifo_count)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stub: latches operands on the first start cycle, pulses done stub_lat cycles later (if enabled).
   initial begin : maxnet_stub
      bit               pend;
      bit               prev;
      int               cnt;
      logic [WIDTH-1:0] res;
      pend = 1'b0; prev = 1'b0; cnt = 0; res = '0;
      mx_done = 1'b0; mx_result = '0;
      forever begin
         tick();
         mx_done = 1'b0;
         if (mx_start && !prev) begin
            pend = 1'b1;
            cnt  = stub_lat;
            res  = mx_x1;
            if (mx_x2 > res) res = mx_x2;
            if (mx_x3 > res) res = mx_x3;
            if (mx_x4 > res) res = mx_x4;
         end else if (pend) begin
            if (cnt > 0) cnt--;
            else if (stub_en) begin
               mx_done   = 1'b1;
               mx_result = res;
               pend      = 1'b0;
            end
         end
         prev = mx_start;
      end
   end

   task automatic push(input int a, input int b, input int c, input int d);
      int n = 0;
      in_x1 = WIDTH'(a); in_x2 = WIDTH'(b); in_x3 = WIDTH'(c); in_x4 = WIDTH'(d);
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) check("push_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         tick();
         cyc++;
      end
      if (!out_valid) check("out_valid_wait", out_valid, 1);
   endtask

   // Returns once the FSM has entered WAIT; hi = cycles mx_start was seen high.
   task automatic wait_start_fall(output int hi);
      int n = 0;
      hi = 0;
      while (!mx_start && n < 200) begin
         tick();
         n++;
      end
      if (!mx_start) check("start_wait", mx_start, 1);
      while (mx_start && hi < 20) begin
         tick();
         hi++;
      end
   endtask

   task automatic take(input string tag, input int res, input int to);
      int c;
      wait_valid(c);
      check({tag, "_result"}, out_result, res);
      check({tag, "_timeout"}, out_timeout, to);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_drop"}, out_valid, 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int c, hi, stable, starts, seen;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_x1 = '0; in_x2 = '0; in_x3 = '0; in_x4 = '0;
      stub_en = 1'b1; stub_lat = 2;
      repeat (3) tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_mx_start", mx_start, 0);
      check("rst_mx_x", {mx_x1, mx_x2, mx_x3, mx_x4}, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", {out_result, out_timeout}, 0);
      check("rst_busy", busy, 0);
      check("rst_count", fifo_count, 0);
      rst = 1'b1;
      tick();

      // Single vector end to end.
      push(1, 2, 3, 4);
      wait_start_fall(hi);
      check("t1_start_len", hi, 2);
      check("t1_mx_x", {mx_x1, mx_x2, mx_x3, mx_x4}, {5'd1, 5'd2, 5'd3, 5'd4});
      check("t1_busy_wait", busy, 1);
      wait_valid(c);
      check("t1_wait_to_valid", c, 2);
      take("t1", 4, 0);
      check("t1_busy_idle", busy, 0);

      // Fill the FIFO while Maxnet stalls, then drain in order.
      stub_en = 1'b0;
      push(1, 2, 3, 4);
      push(31, 0, 5, 9);
      push(7, 7, 2, 1);
      push(3, 16, 8, 15);
      push(9, 0, 0, 9);
      check("t2_count_full", fifo_count, 4);
      check("t2_in_ready", in_ready, 0);
      stub_en = 1'b1;
      take("t2a", 4, 0);
      take("t2b", 31, 0);
      take("t2c", 7, 0);
      take("t2d", 16, 0);
      take("t2e", 9, 0);
      repeat (10) tick();
      check("t2_no_extra", out_valid, 0);
      check("t2_count_end", fifo_count, 0);
      check("t2_busy_end", busy, 0);

      // Downstream backpressure for 20 cycles with pushes arriving.
      push(2, 9, 4, 1);
      wait_valid(c);
      stable = 0; starts = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 0) begin
            in_x1 = 5'd5; in_x2 = 5'd1; in_x3 = 5'd1; in_x4 = 5'd1; in_valid = 1'b1;
         end else if (i == 1) begin
            in_x1 = 5'd0; in_x2 = 5'd0; in_x3 = 5'd0; in_x4 = 5'd3; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (out_valid && out_result == 5'd9 && !out_timeout) stable++;
         if (mx_start) starts++;
      end
      in_valid = 1'b0;
      check("t3_hold", stable, 20);
      check("t3_no_start", starts, 0);
      check("t3_count", fifo_count, 2);
      take("t3a", 9, 0);
      take("t3b", 5, 0);
      take("t3c", 3, 0);

      // Timeout: Maxnet never answers.
      stub_en = 1'b0;
      push(6, 2, 3, 1);
      wait_start_fall(hi);
      wait_valid(c);
      check("t4_cycles", c, 8);
      take("t4", 0, 1);
      stub_en = 1'b1;
      repeat (3) tick();
      check("t4_stale_done", out_valid, 0);
      check("t4_stale_busy", busy, 0);
      push(3, 8, 1, 2);
      take("t4_next", 8, 0);

      // Reset in the middle of WAIT with one vector still queued.
      stub_en = 1'b0;
      push(4, 4, 4, 4);
      push(1, 1, 1, 1);
      wait_start_fall(hi);
      tick();
      tick();
      check("t5_pre_count", fifo_count, 1);
      rst = 1'b0;
      #1;
      check("t5_in_ready", in_ready, 1);
      check("t5_count", fifo_count, 0);
      check("t5_busy", busy, 0);
      check("t5_mx_start", mx_start, 0);
      check("t5_mx_x", {mx_x1, mx_x2, mx_x3, mx_x4}, 0);
      check("t5_out_valid", out_valid, 0);
      check("t5_out", {out_result, out_timeout}, 0);
      tick();
      rst = 1'b1;
      stub_en = 1'b1;
      seen = 0;
      repeat (20) begin
         tick();
         if (out_valid || busy) seen++;
      end
      check("t5_late_done", seen, 0);

      // Done on the last timeout cycle wins; one cycle later loses.
      stub_lat = 8;
      push(17, 3, 5, 0);
      take("t6_tie", 17, 0);
      stub_lat = 9;
      push(12, 3, 5, 0);
      take("t6_late", 0, 1);
      stub_lat = 7;
      push(2, 30, 5, 0);
      take("t6_early", 30, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
